compare_block: RTL and testbench

//  Read-back checker for WRITE_AND_CHECK tests. Sits downstream of transmitter_block.

---
 rtl/compare_block_pkg.sv | 49 ++++
 rtl/compare_block_rnd_data_gen.sv | 42 ++++
 rtl/compare_block.sv | 174 +++++++++++++++++
 tb/tb_compare_block.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/compare_block_pkg.sv
// Shared settings for the read-back checker and its transmitter-side peer.
// Holds the Avalon/test width constants, the transaction descriptor that is
// handed from transmitter_block to compare_block, the data-mode enum and the
// byte-enable helper used by both the write and the check paths.
package compare_block_pkg;

  localparam int AMM_DATA_W  = 32;
  localparam int DATA_B_W    = AMM_DATA_W / 8;
  localparam int ADDR_B_W    = $clog2(DATA_B_W);
  localparam int ADDR_W      = 16;
  localparam int AMM_BURST_W = 5;
  localparam int IDX_W       = AMM_BURST_W - 1;

  // "BYTE": addresses count bytes, first/last words are partially enabled.
  // "WORD": addresses count Avalon words, every byte is always enabled.
  localparam ADDR_TYPE = "BYTE";

  typedef enum logic {
    PTRN     = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_B_W-1:0] start_off;
    logic [ADDR_B_W-1:0] end_off;
    logic [IDX_W-1:0]    words_count;
    data_mode_t          data_mode;
    logic [7:0]          data_ptrn;
  } cmp_struct_t;

  // Byte i is enabled unless it lies before start_off in the first word or
  // after end_off in the last word; a single-word burst applies both bounds.
  function automatic logic [DATA_B_W-1:0] byteenable_mask(
    input logic                first,
    input logic [ADDR_B_W-1:0] start_off,
    input logic                last,
    input logic [ADDR_B_W-1:0] end_off
  );
    logic [DATA_B_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      mask[i] = (!first || (ADDR_B_W'(i) >= start_off)) &&
                (!last  || (ADDR_B_W'(i) <= end_off));
    end
    return mask;
  endfunction

endpackage

// File: rtl/compare_block_rnd_data_gen.sv
// 8-bit LFSR producing the per-word data byte for RND_DATA tests.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, clears the register
//   load_i - load seed_i (has priority over step_i)
//   seed_i - seed value
//   step_i - advance one LFSR step
//   data_o - current LFSR value
module rnd_data_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] data_o
);

  logic [7:0] data_q;
  logic [7:0] data_d;

  // Loading a new seed wins over stepping so that re-arming in the same
  // cycle as a checked beat starts the new sequence cleanly.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = seed_i;
    end else if (step_i) begin
      data_d = {data_q[6:0], data_q[6] ^ data_q[1] ^ data_q[0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/compare_block.sv
// Read-back checker for WRITE_AND_CHECK tests. Latches a transaction
// descriptor on cmp_en_i, regenerates the expected data for every word and
// compares it, byte-masked, against Avalon-MM read data.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   cmp_en_i         - 1-cycle strobe arming the checker with cmp_struct_i
//   cmp_struct_i     - transaction descriptor
//   readdatavalid_i  - Avalon read beat valid
//   readdata_i       - Avalon read data
//   cmp_busy_o       - armed and expecting beats
//   cmp_done_o       - 1-cycle pulse: last beat checked with no error
//   cmp_error_o      - 1-cycle pulse: mismatch detected
//   err_addr_o       - address of the failing word
//   err_data_o       - read data of the failing word
//   err_exp_o        - expected data of the failing word, masked bytes zeroed
module compare_block
  import compare_block_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmp_en_i,
  input  cmp_struct_t           cmp_struct_i,
  input  logic                  readdatavalid_i,
  input  logic [AMM_DATA_W-1:0] readdata_i,
  output logic                  cmp_busy_o,
  output logic                  cmp_done_o,
  output logic                  cmp_error_o,
  output logic [ADDR_W-1:0]     err_addr_o,
  output logic [AMM_DATA_W-1:0] err_data_o,
  output logic [AMM_DATA_W-1:0] err_exp_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  cmp_struct_t           ctx_q, ctx_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [AMM_DATA_W-1:0] err_data_q, err_data_d;
  logic [AMM_DATA_W-1:0] err_exp_q, err_exp_d;

  logic [7:0]            exp_byte;
  logic                  lfsr_load;
  logic                  lfsr_step;
  logic [DATA_B_W-1:0]   mask;
  logic [ADDR_W-1:0]     beat_addr;
  logic                  is_last;
  logic                  beat_chk;
  logic                  mismatch;
  logic [AMM_DATA_W-1:0] exp_word;
  logic [AMM_DATA_W-1:0] exp_masked;

  // The expected byte lives in the LFSR for both modes; in PTRN mode it is
  // simply loaded and never stepped.
  rnd_data_gen u_rnd_data_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (lfsr_load),
    .seed_i (cmp_struct_i.data_ptrn),
    .step_i (lfsr_step),
    .data_o (exp_byte)
  );

  assign is_last  = (idx_q == ctx_q.words_count);
  assign beat_chk = (state_q == ARMED) && readdatavalid_i;
  assign exp_word = {DATA_B_W{exp_byte}};

  // Addressing mode decides both the partial-word mask and how the word
  // index maps onto the reported failing address.
  if (ADDR_TYPE == "BYTE") begin : g_byte_addr
    assign mask      = byteenable_mask(idx_q == '0, ctx_q.start_off, is_last, ctx_q.end_off);
    assign beat_addr = ctx_q.start_addr + (ADDR_W'(idx_q) << ADDR_B_W);
  end else begin : g_word_addr
    assign mask      = '1;
    assign beat_addr = ctx_q.start_addr + ADDR_W'(idx_q);
  end

  // Per-byte compare and the masked expected word reported on error.
  always_comb begin
    mismatch   = 1'b0;
    exp_masked = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      if (mask[i]) begin
        exp_masked[8*i +: 8] = exp_word[8*i +: 8];
        if (readdata_i[8*i +: 8] != exp_word[8*i +: 8]) begin
          mismatch = 1'b1;
        end
      end
    end
  end

  // Next-state logic. A beat arriving with cmp_en_i is judged against the
  // old context first; the new context then takes over. Error capture is
  // applied after the arm-time clear so a coincident failure keeps its
  // diagnostic data.
  always_comb begin
    state_d    = state_q;
    ctx_d      = ctx_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    err_exp_d  = err_exp_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    if (beat_chk) begin
      if (!mismatch) begin
        lfsr_step = (ctx_q.data_mode == RND_DATA);
        if (is_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        error_d = 1'b1;
        state_d = IDLE;
      end
    end

    if (cmp_en_i) begin
      state_d    = ARMED;
      ctx_d      = cmp_struct_i;
      idx_d      = '0;
      lfsr_load  = 1'b1;
      err_addr_d = '0;
      err_data_d = '0;
      err_exp_d  = '0;
    end

    if (beat_chk && mismatch) begin
      err_addr_d = beat_addr;
      err_data_d = readdata_i;
      err_exp_d  = exp_masked;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ctx_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
      err_exp_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctx_q      <= ctx_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      err_exp_q  <= err_exp_d;
    end
  end

  assign cmp_busy_o  = (state_q == ARMED);
  assign cmp_done_o  = done_q;
  assign cmp_error_o = error_q;
  assign err_addr_o  = err_addr_q;
  assign err_data_o  = err_data_q;
  assign err_exp_o   = err_exp_q;

endmodule

// File: tb/tb_compare_block.sv
// Directed self-checking bench for compare_block (DATA_B_W=4, BYTE mode).
module tb_compare_block;
  import compare_block_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  cmp_en_i = 1'b0;
  cmp_struct_t           cmp_struct_i = '0;
  logic                  readdatavalid_i = 1'b0;
  logic [AMM_DATA_W-1:0] readdata_i = '0;
  logic                  cmp_busy_o;
  logic                  cmp_done_o;
  logic                  cmp_error_o;
  logic [ADDR_W-1:0]     err_addr_o;
  logic [AMM_DATA_W-1:0] err_data_o;
  logic [AMM_DATA_W-1:0] err_exp_o;

  int checks = 0;
  int errors = 0;

  compare_block dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cmp_en_i        (cmp_en_i),
    .cmp_struct_i    (cmp_struct_i),
    .readdatavalid_i (readdatavalid_i),
    .readdata_i      (readdata_i),
    .cmp_busy_o      (cmp_busy_o),
    .cmp_done_o      (cmp_done_o),
    .cmp_error_o     (cmp_error_o),
    .err_addr_o      (err_addr_o),
    .err_data_o      (err_data_o),
    .err_exp_o       (err_exp_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change #1 after the rising edge; outputs registered on that edge
  // are sampled at the same point.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic arm(input logic [ADDR_W-1:0] addr, input logic [1:0] so,
                     input logic [1:0] eo, input logic [IDX_W-1:0] wc,
                     input data_mode_t mode, input logic [7:0] ptrn);
    cmp_struct_i.start_addr  = addr;
    cmp_struct_i.start_off   = so;
    cmp_struct_i.end_off     = eo;
    cmp_struct_i.words_count = wc;
    cmp_struct_i.data_mode   = mode;
    cmp_struct_i.data_ptrn   = ptrn;
    cmp_en_i = 1'b1;
    tick();
    cmp_en_i = 1'b0;
  endtask

  task automatic beat(input logic [AMM_DATA_W-1:0] d);
    readdatavalid_i = 1'b1;
    readdata_i      = d;
    tick();
    readdatavalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    checks++; if (cmp_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b exp 0", cmp_busy_o); end
    checks++; if (cmp_done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b exp 0", cmp_done_o); end
    checks++; if (cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %b exp 0", cmp_error_o); end
    checks++; if (err_addr_o !== '0) begin errors++; $display("[TB] FAIL reset_err_addr: got %h exp 0", err_addr_o); end
    checks++; if (err_data_o !== '0) begin errors++; $display("[TB] FAIL reset_err_data: got %h exp 0", err_data_o); end
    checks++; if (err_exp_o !== '0) begin errors++; $display("[TB] FAIL reset_err_exp: got %h exp 0", err_exp_o); end
  endtask

  task automatic test_ptrn_single();
    arm(16'h0100, 2'd0, 2'd3, 4'd0, PTRN, 8'hA5);
    checks++; if (cmp_busy_o !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b exp 1", cmp_busy_o); end
    beat(32'hA5A5A5A5);
    checks++; if (cmp_done_o !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %b exp 1", cmp_done_o); end
    checks++; if (cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL single_error: got %b exp 0", cmp_error_o); end
    checks++; if (cmp_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b exp 0", cmp_busy_o); end
    tick();
    checks++; if (cmp_done_o !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %b exp 0", cmp_done_o); end
  endtask

  task automatic test_ptrn_masked();
    // Two words, first word bytes 2-3 live, last word bytes 0-1 live.
    arm(16'h0200, 2'd2, 2'd1, 4'd1, PTRN, 8'h3C);
    beat(32'h3C3C1122);
    checks++; if (cmp_done_o !== 1'b0 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL masked_beat0: got done=%b err=%b exp 0 0", cmp_done_o, cmp_error_o); end
    checks++; if (cmp_busy_o !== 1'b1) begin errors++; $display("[TB] FAIL masked_busy: got %b exp 1", cmp_busy_o); end
    beat(32'hDEAD3C3C);
    checks++; if (cmp_done_o !== 1'b1 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL masked_done: got done=%b err=%b exp 1 0", cmp_done_o, cmp_error_o); end
    // Corrupt byte 2 of the first word.
    arm(16'h0200, 2'd2, 2'd1, 4'd1, PTRN, 8'h3C);
    beat(32'h3C770000);
    checks++; if (cmp_error_o !== 1'b1 || cmp_done_o !== 1'b0) begin errors++; $display("[TB] FAIL masked_error: got err=%b done=%b exp 1 0", cmp_error_o, cmp_done_o); end
    checks++; if (err_addr_o !== 16'h0200) begin errors++; $display("[TB] FAIL masked_err_addr: got %h exp 0200", err_addr_o); end
    checks++; if (err_data_o !== 32'h3C770000) begin errors++; $display("[TB] FAIL masked_err_data: got %h exp 3c770000", err_data_o); end
    checks++; if (err_exp_o !== 32'h3C3C0000) begin errors++; $display("[TB] FAIL masked_err_exp: got %h exp 3c3c0000", err_exp_o); end
    checks++; if (cmp_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL masked_err_idle: got %b exp 0", cmp_busy_o); end
    // Leftover beat of the failed burst is ignored; err regs hold.
    beat(32'hDEAD3C3C);
    checks++; if (cmp_done_o !== 1'b0 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL masked_leftover: got done=%b err=%b exp 0 0", cmp_done_o, cmp_error_o); end
    checks++; if (err_addr_o !== 16'h0200) begin errors++; $display("[TB] FAIL masked_err_hold: got %h exp 0200", err_addr_o); end
  endtask

  task automatic test_rnd();
    // Seed 01 walks 01,03,06,0D under the shift-left LFSR.
    arm(16'h0300, 2'd0, 2'd3, 4'd3, RND_DATA, 8'h01);
    checks++; if (err_addr_o !== '0 || err_exp_o !== '0) begin errors++; $display("[TB] FAIL rnd_arm_clear: got addr=%h exp_word=%h exp 0 0", err_addr_o, err_exp_o); end
    beat(32'h01010101);
    beat(32'h03030303);
    beat(32'h06060606);
    checks++; if (cmp_done_o !== 1'b0 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_mid: got done=%b err=%b exp 0 0", cmp_done_o, cmp_error_o); end
    beat(32'h0D0D0D0D);
    checks++; if (cmp_done_o !== 1'b1 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_done: got done=%b err=%b exp 1 0", cmp_done_o, cmp_error_o); end
    arm(16'h0300, 2'd0, 2'd3, 4'd3, RND_DATA, 8'h01);
    beat(32'h01010101);
    beat(32'h03030303);
    beat(32'h07070707);
    checks++; if (cmp_error_o !== 1'b1) begin errors++; $display("[TB] FAIL rnd_error: got %b exp 1", cmp_error_o); end
    checks++; if (err_exp_o !== 32'h06060606) begin errors++; $display("[TB] FAIL rnd_err_exp: got %h exp 06060606", err_exp_o); end
    checks++; if (err_addr_o !== 16'h0308) begin errors++; $display("[TB] FAIL rnd_err_addr: got %h exp 0308", err_addr_o); end
  endtask

  task automatic test_idle_beats();
    for (int i = 0; i < 3; i++) begin
      beat(32'h12345678 + i);
      checks++; if (cmp_done_o !== 1'b0 || cmp_error_o !== 1'b0 || cmp_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_beat%0d: got done=%b err=%b busy=%b exp 0 0 0", i, cmp_done_o, cmp_error_o, cmp_busy_o); end
    end
  endtask

  task automatic test_back_to_back();
    arm(16'h0400, 2'd0, 2'd3, 4'd1, PTRN, 8'h55);
    // New arm coincides with a failing beat of the old context.
    cmp_struct_i.start_addr  = 16'h0500;
    cmp_struct_i.start_off   = 2'd0;
    cmp_struct_i.end_off     = 2'd3;
    cmp_struct_i.words_count = 4'd0;
    cmp_struct_i.data_mode   = PTRN;
    cmp_struct_i.data_ptrn   = 8'hA5;
    cmp_en_i        = 1'b1;
    readdatavalid_i = 1'b1;
    readdata_i      = 32'h00000000;
    tick();
    cmp_en_i        = 1'b0;
    readdatavalid_i = 1'b0;
    checks++; if (cmp_error_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_error: got %b exp 1", cmp_error_o); end
    checks++; if (cmp_busy_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rearmed: got %b exp 1", cmp_busy_o); end
    beat(32'hA5A5A5A5);
    checks++; if (cmp_done_o !== 1'b1 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_new_done: got done=%b err=%b exp 1 0", cmp_done_o, cmp_error_o); end
  endtask

  task automatic test_reset_mid();
    arm(16'h0600, 2'd0, 2'd3, 4'd3, PTRN, 8'h81);
    beat(32'h81818181);
    rst_i           = 1'b1;
    readdatavalid_i = 1'b1;
    readdata_i      = 32'h00000000;
    tick();
    rst_i           = 1'b0;
    readdatavalid_i = 1'b0;
    checks++; if (cmp_busy_o !== 1'b0 || cmp_done_o !== 1'b0 || cmp_error_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs: got busy=%b done=%b err=%b exp 0 0 0", cmp_busy_o, cmp_done_o, cmp_error_o); end
    checks++; if (err_addr_o !== '0 || err_data_o !== '0 || err_exp_o !== '0) begin errors++; $display("[TB] FAIL rstmid_err_regs: got %h %h %h exp 0", err_addr_o, err_data_o, err_exp_o); end
    beat(32'h81818181);
    beat(32'h00000000);
    checks++; if (cmp_done_o !== 1'b0 || cmp_error_o !== 1'b0 || cmp_busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ignored: got done=%b err=%b busy=%b exp 0 0 0", cmp_done_o, cmp_error_o, cmp_busy_o); end
  endtask

  initial begin
    test_reset();
    test_ptrn_single();
    test_ptrn_masked();
    test_rnd();
    test_idle_beats();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
